asu_riscv_mult_seq: RTL and testbench

Issue/retire sequencer for the RV32M multiply unit. Sits between the execute-stage issue logic and the `asu_riscv_multiplier` datapath. It accepts MUL/MULH/MULHSU/MULHU requests through a valid/ready handshake and registers the operands. It then drives the multiplier's `operator_i`/`signed_mode_i`/operands for the exact number of cycles the datapath needs: one for MUL, two for high-half ops. It captures the result and presents it to writeback through a second valid/ready handshake.

---
 rtl/asu_riscv_mult_seq.sv | 181 ++++++++++++++++++
 tb/tb_asu_riscv_mult_seq.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asu_riscv_mult_seq.sv
// ----------------------------------------------------------------------------
// asu_riscv_mult_seq
//
// Issue/retire sequencer for the RV32M multiply unit. It takes MUL, MULH,
// MULHSU and MULHU requests from the execute stage, registers the operands,
// and drives the external multiplier datapath for exactly as many cycles as
// the operation needs: one for MUL, two for the high-half ops. It captures
// the result and hands it to writeback with its destination tag.
//
// Build option:
//   ASU_MULT_ZERO_SKIP_EN - when defined, a request with a zero operand skips
//                           the multiplier. It goes straight to the response
//                           with data 0, so the latency is one cycle for every
//                           funct3.
//
// Ports:
//   clk, nrst           clock; asynchronous active-low reset
//   req_valid_i/ready_o request handshake
//   funct3_i            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (1xx -> MUL)
//   rs1_i, rs2_i, rd_i  operands and destination tag
//   flush_i             abort any in-flight op, including a pending response
//   rsp_valid_o/ready_i response handshake
//   rsp_data_o, rsp_rd_o result and destination tag
//   mul_operator_o      to multiplier: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   mul_signed_mode_o   bit0 = rs1 signed, bit1 = rs2 signed
//   mul_op_a_o/_b_o     operands to multiplier
//   mul_result_i        result from multiplier
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, rsp_valid_o stays high with stable data and tag
// until it is taken or flushed. req_ready_o depends on rsp_ready_i and
// flush_i but never on req_valid_i.
// ----------------------------------------------------------------------------
module asu_riscv_mult_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [4:0]      rsp_rd_o,
    output logic [1:0]      mul_operator_o,
    output logic [1:0]      mul_signed_mode_o,
    output logic [XLEN-1:0] mul_op_a_o,
    output logic [XLEN-1:0] mul_op_b_o,
    input  logic [XLEN-1:0] mul_result_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EX1  = 2'd1,
        S_EX2  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [4:0]      rsp_rd_q;

    logic            accept;
    logic            zero_skip;
    logic            capture;
    logic            in_ex;
    logic [1:0]      op_dec;
    logic [1:0]      sm_dec;

    // A new request can be taken when idle, or in the same cycle the pending
    // response leaves. A flush always blocks acceptance.
    assign req_ready_o = !flush_i &&
                         ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

`ifdef ASU_MULT_ZERO_SKIP_EN
    assign zero_skip = accept && ((rs1_i == '0) || (rs2_i == '0));
`else
    assign zero_skip = 1'b0;
`endif

    // Illegal funct3 (bit2 set) runs as a plain MUL.
    always_comb begin
        op_dec = f3_q[2] ? 2'b00 : f3_q[1:0];
        case (op_dec)
            2'b01:   sm_dec = 2'b11;   // MULH
            2'b10:   sm_dec = 2'b01;   // MULHSU
            default: sm_dec = 2'b00;   // MUL, MULHU
        endcase
    end

    // The multiplier sees zeros outside EX so that its internal step state
    // always falls back to 0, even after a flush cuts an op short.
    assign in_ex             = (state_q == S_EX1) || (state_q == S_EX2);
    assign mul_operator_o    = in_ex ? op_dec : 2'b00;
    assign mul_signed_mode_o = in_ex ? sm_dec : 2'b00;
    assign mul_op_a_o        = in_ex ? rs1_q  : '0;
    assign mul_op_b_o        = in_ex ? rs2_q  : '0;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = zero_skip ? S_RESP : S_EX1;
            end
            S_EX1: begin
                if (op_dec == 2'b00) begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end else begin
                    state_d = S_EX2;
                end
            end
            S_EX2: begin
                state_d = S_RESP;
                capture = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    if (accept) state_d = zero_skip ? S_RESP : S_EX1;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything and drops the result.
        if (flush_i) begin
            state_d = S_IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rs1_q <= '0;
            rs2_q <= '0;
            f3_q  <= 3'b000;
            rd_q  <= 5'd0;
        end else if (accept) begin
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
            f3_q  <= funct3_i;
            rd_q  <= rd_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_data_q <= '0;
            rsp_rd_q   <= 5'd0;
        end else if (capture) begin
            rsp_data_q <= mul_result_i;
            rsp_rd_q   <= rd_q;
        end else if (zero_skip) begin
            rsp_data_q <= '0;
            rsp_rd_q   <= rd_i;
        end
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_rd_o    = rsp_rd_q;

endmodule

// File: tb/tb_asu_riscv_mult_seq.sv
// ----------------------------------------------------------------------------
// tb_asu_riscv_mult_seq
//
// Bench for asu_riscv_mult_seq. A small behavioural multiplier stands in for
// the datapath: it returns the low product at once for operator 00. For the
// high-half operators it returns garbage in the first step and the high
// product in the second step. Expected responses come from plain 64-bit
// arithmetic on the request fields.
// ----------------------------------------------------------------------------
module tb_asu_riscv_mult_seq;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  mul_operator_o;
    logic [1:0]  mul_signed_mode_o;
    logic [31:0] mul_op_a_o;
    logic [31:0] mul_op_b_o;
    logic [31:0] mul_result;

    asu_riscv_mult_seq #(.XLEN(32)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .funct3_i          (funct3),
        .rs1_i             (rs1),
        .rs2_i             (rs2),
        .rd_i              (rd),
        .flush_i           (flush),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready),
        .rsp_data_o        (rsp_data_o),
        .rsp_rd_o          (rsp_rd_o),
        .mul_operator_o    (mul_operator_o),
        .mul_signed_mode_o (mul_signed_mode_o),
        .mul_op_a_o        (mul_op_a_o),
        .mul_op_b_o        (mul_op_b_o),
        .mul_result_i      (mul_result)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier stand-in ----------------
    logic mstate;
    always @(posedge clk or negedge nrst) begin
        if (!nrst)                     mstate <= 1'b0;
        else if (mul_operator_o != 0)  mstate <= ~mstate;
        else                           mstate <= 1'b0;
    end

    function automatic logic [31:0] mult_env(input logic [1:0] op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic st);
        logic [63:0] ea, eb, p;
        ea = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        if (op == 2'b00) return p[31:0];
        if (st)          return p[63:32];
        return 32'hDEADBEEF;
    endfunction

    always_comb mul_result = mult_env(mul_operator_o, mul_signed_mode_o,
                                      mul_op_a_o, mul_op_b_o, mstate);

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'b001:  return 32'(((sa * sb) >> 32));
            3'b010:  return 32'(((sa * ub) >> 32));
            3'b011:  return 32'(((ua * ub) >> 32));
            default: begin
                p = ua * ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
`ifdef ASU_MULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) return 3;
        return 2;
    endfunction

    function automatic logic [1:0] ref_op(input logic [2:0] f3);
        return f3[2] ? 2'b00 : f3[1:0];
    endfunction

    function automatic logic [1:0] ref_sm(input logic [1:0] op);
        case (op)
            2'b01:   return 2'b11;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int last_hs_cyc = -1;
    int act_cnt = 0;
    int match_cnt = 0;
    logic [1:0]  exp_op = 2'b00;
    logic [1:0]  exp_sm = 2'b00;
    logic [31:0] exp_a = 32'h0;
    logic [31:0] exp_b = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic drop_last();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(acc_q.pop_back());
            void'(lat_q.pop_back());
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        prev_valid, prev_hs, prev_flush;
        logic [31:0] prev_data;
        logic [4:0]  prev_rd;
        int          valid_start;
        logic [36:0] e;
        int          a_c, l_c;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_flush = 1'b0;
        prev_data = 32'h0; prev_rd = 5'd0; valid_start = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_valid = 1'b0; prev_hs = 1'b0; prev_flush = 1'b0;
            end else begin
                if (rsp_valid_o && (!prev_valid || prev_hs)) valid_start = cyc;
                if (prev_valid && !prev_hs && !prev_flush) begin
                    check("rsp_hold_valid", 64'(rsp_valid_o), 64'(1));
                    check("rsp_hold_data", 64'({rsp_rd_o, rsp_data_o}), 64'({prev_rd, prev_data}));
                end
                if (rsp_valid_o && rsp_ready && !flush) begin
                    hs_cnt++;
                    last_hs_cyc = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: actual rd=%0d data=0x%0h required no response",
                                 rsp_rd_o, rsp_data_o);
                    end else begin
                        e   = exp_q.pop_front();
                        a_c = acc_q.pop_front();
                        l_c = lat_q.pop_front();
                        check("rsp_rd_data", 64'({rsp_rd_o, rsp_data_o}), 64'(e));
                        check("rsp_latency", 64'(valid_start - a_c + 1), 64'(l_c));
                    end
                end
                if (mul_operator_o != 0 || mul_signed_mode_o != 0 ||
                    mul_op_a_o != 0 || mul_op_b_o != 0) begin
                    act_cnt++;
                    if (mul_operator_o == exp_op && mul_signed_mode_o == exp_sm &&
                        mul_op_a_o == exp_a && mul_op_b_o == exp_b) match_cnt++;
                end
                prev_hs    = rsp_valid_o && rsp_ready && !flush;
                prev_valid = rsp_valid_o;
                prev_flush = flush;
                prev_data  = rsp_data_o;
                prev_rd    = rsp_rd_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and holds it until accepted; returns the number of
    // the rising edge that accepted it.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output int acc);
        acc = -1;
        req_valid = 1'b1;
        funct3 = f3;
        rs1 = a;
        rs2 = b;
        rd = r;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = cyc + 1;
                exp_q.push_back({r, ref_result(f3, a, b)});
                acc_q.push_back(acc);
                lat_q.push_back(ref_latency(f3, a, b));
                step();
                break;
            end
            step();
        end
        req_valid = 1'b0;
        if (acc < 0) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end
        step();
        step();
    endtask

    task automatic wait_valid(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now(name);
    endtask

    task automatic run_one(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input int exp_act, input string name);
        int acc, h0;
        exp_op = ref_op(f3);
        exp_sm = ref_sm(exp_op);
        exp_a = a;
        exp_b = b;
        act_cnt = 0;
        match_cnt = 0;
        h0 = hs_cnt;
        issue(f3, a, b, r, acc);
        wait_idle();
        check({name, "_ex_cycles"}, 64'(act_cnt), 64'(exp_act));
        check({name, "_ex_match"}, 64'(match_cnt), 64'(exp_act));
        check({name, "_handshakes"}, 64'(hs_cnt - h0), 64'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc, acc2, h0, fe;
        logic done;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_rsp_data", 64'(rsp_data_o), 64'(0));
        check("rst_rsp_rd", 64'(rsp_rd_o), 64'(0));
        check("rst_mul_outputs", 64'({mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o}), 64'(0));
        step();
        nrst = 1'b1;
        rsp_ready = 1'b1;
        step();

        // MUL 7 x -3.
        run_one(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, "mul_7x-3");
        @(negedge clk);
        check("idle_mul_outputs", 64'({mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o}), 64'(0));
        step();

        // High-half ops on 0x80000000 x 0xFFFFFFFF.
        run_one(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 2, "mulh");
        run_one(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 2, "mulhsu");
        run_one(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 2, "mulhu");
        // Illegal funct3 runs as MUL.
        run_one(3'b110, 32'h0001_0003, 32'h0000_0100, 5'd13, 1, "illegal_f3");

        // Back-to-back with the second accept on the first response handshake.
        h0 = hs_cnt;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, acc);
        issue(3'b000, 32'd3, 32'd4, 5'd2, acc2);
        check("b2b_accept_on_handshake", 64'(acc2), 64'(last_hs_cyc));
        @(negedge clk);
        check("b2b_valid_low_in_ex1", 64'(rsp_valid_o), 64'(0));
        step();
        wait_idle();
        check("b2b_handshakes", 64'(hs_cnt - h0), 64'(2));

        // Backpressure: MUL 2 x 2 held for 5 cycles.
        rsp_ready = 1'b0;
        h0 = hs_cnt;
        issue(3'b000, 32'd2, 32'd2, 5'd4, acc);
        wait_valid("bp_valid_timeout");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_valid_held", 64'(rsp_valid_o), 64'(1));
            check("bp_data_held", 64'(rsp_data_o), 64'(4));
            check("bp_req_ready_low", 64'(req_ready_o), 64'(0));
        end
        step();
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_valid_drop", 64'(rsp_valid_o), 64'(0));
        check("bp_single_handshake", 64'(hs_cnt - h0), 64'(1));
        step();

        // Flush in EX1 of MULH, then MUL 5 x 6 the next cycle.
        h0 = hs_cnt;
        issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, acc);
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", 64'(req_ready_o), 64'(0));
        fe = cyc + 1;
        step();
        flush = 1'b0;
        drop_last();
        issue(3'b000, 32'd5, 32'd6, 5'd3, acc2);
        check("flush_next_accept", 64'(acc2), 64'(fe + 1));
        wait_idle();
        check("flush_ex1_handshakes", 64'(hs_cnt - h0), 64'(1));

        // Flush in RESP together with rsp_ready and a waiting request.
        rsp_ready = 1'b0;
        h0 = hs_cnt;
        issue(3'b000, 32'd9, 32'd9, 5'd6, acc);
        wait_valid("flush_resp_valid_timeout");
        step();
        flush = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        funct3 = 3'b000;
        rs1 = 32'd1;
        rs2 = 32'd1;
        @(negedge clk);
        check("flush_wins_ready", 64'(req_ready_o), 64'(0));
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        drop_last();
        @(negedge clk);
        check("flush_resp_valid_drop", 64'(rsp_valid_o), 64'(0));
        for (int k = 0; k < 6; k++) step();
        check("flush_resp_no_handshake", 64'(hs_cnt - h0), 64'(0));

        // Zero operand: skips EX when the option is built in.
`ifdef ASU_MULT_ZERO_SKIP_EN
        run_one(3'b001, 32'h0, 32'h1234_5678, 5'd7, 0, "zero_mulh");
`else
        run_one(3'b001, 32'h0, 32'h1234_5678, 5'd7, 2, "zero_mulh");
`endif

        // Reset asserted in the middle of EX2.
        issue(3'b001, 32'h7FFF_0001, 32'h0003_0005, 5'd8, acc);
        step();
        nrst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        #1;
        check("midrst_req_ready", 64'(req_ready_o), 64'(1));
        check("midrst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("midrst_rsp", 64'({rsp_rd_o, rsp_data_o}), 64'(0));
        check("midrst_mul_outputs", 64'({mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o}), 64'(0));
        step();
        nrst = 1'b1;
        step();
        run_one(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd14, 2, "after_reset");

        // Randomized traffic with random writeback backpressure.
        done = 1'b0;
        fork
            begin
                int a_r;
                logic [31:0] opv[2];
                for (int n = 0; n < 150; n++) begin
                    for (int j = 0; j < 2; j++) begin
                        case ($urandom_range(0, 7))
                            0:       opv[j] = 32'h0;
                            1:       opv[j] = 32'hFFFF_FFFF;
                            2:       opv[j] = 32'h8000_0000;
                            3:       opv[j] = 32'h7FFF_FFFF;
                            default: opv[j] = $urandom;
                        endcase
                    end
                    issue(3'($urandom_range(0, 7)), opv[0], opv[1],
                          5'($urandom_range(0, 31)), a_r);
                    for (int g = $urandom_range(0, 2); g > 0; g--) step();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        checks++;
        failures++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
